// File: rtl/nibble_serial_add_ctrl.sv
// Wide add/subtract built from one NIB-bit adder slice, one slice per cycle, LSB slice first.
// done pulses N+1 cycles after start is accepted; start is only honoured in IDLE and never queued.
module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16,
  parameter int NIB   = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int N  = WIDTH / NIB;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = NIB + 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [NIB-1:0]   a_sl, b_sl;
  logic [SW-1:0]    slice_res;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    a_sl    = '0;
    b_sl    = '0;

    // Shared slice adder: constant-index mux keeps the select a plain N-way mux.
    for (int i = 0; i < N; i++) begin
      if (k_q == KW'(i)) begin
        a_sl = a_q[i*NIB +: NIB];
        b_sl = b_q[i*NIB +: NIB];
      end
    end
    slice_res = {1'b0, a_sl} + {1'b0, b_sl} + SW'(carry_q);

    case (state_q)
      IDLE: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = sub_i ? ~b_i : b_i;
          carry_d = sub_i ? 1'b1 : cin_i;
          k_d     = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < N; i++) begin
          if (k_q == KW'(i)) begin
            sum_d[i*NIB +: NIB] = slice_res[NIB-1:0];
          end
        end
        carry_d = slice_res[NIB];
        if (k_q == K_LAST) begin
          cout_d  = slice_res[NIB];
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_res[NIB-1] != a_q[WIDTH-1]);
          k_d     = '0;
          state_d = DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_o = (state_q == RUN);
  assign done_o = (state_q == DONE);
  assign sum_o  = sum_q;
  assign cout_o = cout_q;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Bench for nibble_serial_add_ctrl: directed vectors with hand-computed results,
// expected results queued at issue and checked by an independent done monitor.
module tb_nibble_serial_add_ctrl;

  localparam int WIDTH = 16;
  localparam int NIB   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } exp_t;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } vec_t;

  exp_t exp_q[$];

  nibble_serial_add_ctrl #(.WIDTH(WIDTH), .NIB(NIB)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .sub_i   (sub),
    .a_i     (a),
    .b_i     (b),
    .cin_i   (cin),
    .busy_o  (busy),
    .done_o  (done),
    .sum_o   (sum),
    .cout_o  (cout),
    .ovf_o   (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (done) begin
      if (prev_done) chk("done_single_cycle", 32'd1, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sum", 32'(sum), 32'(e.sum));
        chk("cout", 32'(cout), 32'(e.cout));
        chk("ovf", 32'(ovf), 32'(e.ovf));
      end
    end
    prev_done = done;
  end

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.sum  = v.sum;
    e.cout = v.cout;
    e.ovf  = v.ovf;
    exp_q.push_back(e);
  endtask

  // One operation from IDLE with latency/busy checks; result checked by the monitor.
  task automatic run_op(input vec_t v);
    @(negedge clk);
    a = v.a; b = v.b; sub = v.sub; cin = v.cin; start = 1'b1;
    push_exp(v);
    @(negedge clk);
    start = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF; sub = ~v.sub; cin = ~v.cin;
    for (int i = 1; i <= 4; i++) begin
      chk("busy_run", 32'(busy), 32'd1);
      chk("done_early", 32'(done), 32'd0);
      @(negedge clk);
    end
    chk("done_latency", 32'(done), 32'd1);
    chk("busy_in_done", 32'(busy), 32'd0);
    @(negedge clk);
    chk("done_after", 32'(done), 32'd0);
  endtask

  vec_t vecs[8];
  vec_t held[3];

  initial begin
    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'h000F, 16'h0000, 1'b0, 1'b1, 16'h0010, 1'b0, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[6] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b1};
    held[0] = '{16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0};
    held[1] = '{16'hA000, 16'h6000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    held[2] = '{16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h00FE, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);

    foreach (vecs[i]) run_op(vecs[i]);

    // Results hold in IDLE while start stays low.
    repeat (3) @(negedge clk);
    chk("hold_sum", 32'(sum), 32'h0001);
    chk("hold_cout", 32'(cout), 32'd1);

    // start held high, operands churn except on the capture cycles.
    for (int j = 0; j < 18; j++) begin
      @(negedge clk);
      chk("held_done_phase", 32'(done), (j % 6 == 5) ? 32'd1 : 32'd0);
      start = 1'b1;
      if (j % 6 == 0) begin
        a = held[j/6].a; b = held[j/6].b; sub = held[j/6].sub; cin = held[j/6].cin;
        push_exp(held[j/6]);
      end else begin
        a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
      end
    end
    @(negedge clk);
    start = 1'b0;

    // Reset in the 2nd RUN cycle discards the operation.
    repeat (2) @(negedge clk);
    a = 16'h1234; b = 16'h1111; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_cout", 32'(cout), 32'd0);
    chk("midrst_ovf", 32'(ovf), 32'd0);
    repeat (8) @(negedge clk);
    chk("midrst_no_done", 32'(done), 32'd0);

    run_op(vecs[3]);
    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
